// File: rtl/mmio_timer_io.sv
// mmio_timer_io: MMIO responder with LED register, synchronised switches,
// a down-counting timer with sticky expiry/IRQ, and a switch-0 rising-edge counter.
module mmio_timer_io #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int LED_W = 8,
  parameter int SW_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      A,
  input  logic             WE,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  output logic             SEL,
  input  logic [SW_W-1:0]  SWITCH,
  output logic [LED_W-1:0] LED,
  output logic             IRQ
);
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw1_q, sw1_d, sw2_q, sw2_d;
  logic prev_q, prev_d;
  logic [31:0] load_q, load_d, count_q, count_d, edges_q, edges_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic expired_q, expired_d;
  logic [5:0] off;
  logic wr, expire, unused_a;
  assign off = A[7:2];
  assign unused_a = ^A[1:0];
  assign SEL = A[31:8] == BASE_ADDR[31:8];
  assign wr = WE & SEL;
  always_comb begin
    led_d = (wr && off == 6'd0) ? WD[LED_W-1:0] : led_q;
    load_d = (wr && off == 6'd2) ? WD : load_q;
    sw1_d = SWITCH;
    sw2_d = sw1_q;
    prev_d = sw2_q[0];
    count_d = count_q;
    ctrl_d = ctrl_q;
    expire = 1'b0;
    if (wr && off == 6'd2) count_d = WD;
    else if (ctrl_q[0] && count_q > 32'd1) count_d = count_q - 32'd1;
    else if (ctrl_q[0] && count_q == 32'd1) begin
      expire = 1'b1;
      count_d = ctrl_q[1] ? load_q : 32'd0;
      ctrl_d[0] = ctrl_q[1];
    end
    if (wr && off == 6'd4) ctrl_d = WD[2:0];
    // a coincident expiry beats a software clear of the sticky flag
    expired_d = expire | (expired_q & ~(wr && off == 6'd5 && WD[0]));
    edges_d = (wr && off == 6'd6) ? 32'd0 : (sw2_q[0] && !prev_q) ? edges_q + 32'd1 : edges_q;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      prev_q <= 1'b0;
      load_q <= '0;
      count_q <= '0;
      ctrl_q <= '0;
      expired_q <= 1'b0;
      edges_q <= '0;
    end else begin
      led_q <= led_d;
      sw1_q <= sw1_d;
      sw2_q <= sw2_d;
      prev_q <= prev_d;
      load_q <= load_d;
      count_q <= count_d;
      ctrl_q <= ctrl_d;
      expired_q <= expired_d;
      edges_q <= edges_d;
    end
  end
  assign RD = !SEL ? 32'd0 :
              off == 6'd0 ? 32'(led_q) :
              off == 6'd1 ? 32'(sw2_q) :
              off == 6'd2 ? load_q :
              off == 6'd3 ? count_q :
              off == 6'd4 ? {29'd0, ctrl_q} :
              off == 6'd5 ? {31'd0, expired_q} :
              off == 6'd6 ? edges_q : 32'd0;
  assign LED = led_q;
  assign IRQ = expired_q & ctrl_q[2];
endmodule

// File: tb/tb_mmio_timer_io.sv
// tb_mmio_timer_io: directed plan checks plus random bus traffic against a register-level model.
module tb_mmio_timer_io;
  localparam logic [31:0] BASE = 32'h0000_FF00;
  logic CLK = 0, RESET = 0, WE = 0, SEL, IRQ;
  logic [31:0] A = 0, WD = 0, RD;
  logic [7:0] SWITCH = 0, LED;
  int total = 0, bad = 0;
  logic [7:0] m_led, hist [3];
  logic [31:0] m_load, m_count, m_edges;
  logic [2:0] m_ctrl;
  logic m_exp;

  always #5 CLK = ~CLK;

  mmio_timer_io dut (.CLK(CLK), .RESET(RESET), .A(A), .WE(WE), .WD(WD), .RD(RD),
                     .SEL(SEL), .SWITCH(SWITCH), .LED(LED), .IRQ(IRQ));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = 0; m_load = 0; m_count = 0; m_edges = 0; m_ctrl = 0; m_exp = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
  endtask

  // hist[0] is the newest switch sample; the synchronised view lags by one more sample
  task automatic model_edge();
    logic w, fire, rise;
    logic [5:0] o;
    w = WE && (A[31:8] == BASE[31:8]);
    o = A[7:2];
    fire = 0;
    rise = hist[1][0] && !hist[2][0];
    if (w && o == 0) m_led = WD[7:0];
    if (w && o == 2) begin m_load = WD; m_count = WD; end
    else if (m_ctrl[0] && m_count == 1) begin
      fire = 1;
      m_count = m_ctrl[1] ? m_load : 0;
      if (!m_ctrl[1]) m_ctrl[0] = 0;
    end else if (m_ctrl[0] && m_count != 0) m_count = m_count - 1;
    if (w && o == 4) m_ctrl = WD[2:0];
    if (w && o == 5 && WD[0]) m_exp = 0;
    if (fire) m_exp = 1;
    if (rise) m_edges = m_edges + 1;
    if (w && o == 6) m_edges = 0;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = SWITCH;
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return 0;
    case (a[7:2])
      0: return {24'd0, m_led};
      1: return {24'd0, hist[1]};
      2: return m_load;
      3: return m_count;
      4: return {29'd0, m_ctrl};
      5: return {31'd0, m_exp};
      6: return m_edges;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    if (RESET) model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    A = BASE + {24'd0, off}; WD = d; WE = 1;
    tick();
    WE = 0;
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    A = BASE + {24'd0, off};
    #1;
    check(tag, RD, exp);
  endtask

  initial begin
    model_reset();
    #12;
    for (int i = 0; i < 7; i++) rd("reset_reg", 8'(i * 4), 0);
    check("reset_irq", {31'd0, IRQ}, 0);
    check("reset_led", {24'd0, LED}, 0);
    RESET = 1;

    wr(8'h00, 32'h0000_00A5);
    check("led_out", {24'd0, LED}, 32'hA5);
    rd("led_rd", 8'h00, 32'hA5);
    A = BASE + 32'h100; #1;
    check("unsel_sel", {31'd0, SEL}, 0);
    check("unsel_rd", RD, 0);
    A = BASE; #1;
    check("sel", {31'd0, SEL}, 1);
    wr(8'h1C, 32'hFFFF_FFFF);
    rd("unmapped_rd", 8'h1C, 0);
    for (int i = 0; i < 7; i++) rd("unmapped_wr", 8'(i * 4), m_rd(BASE + 32'(i * 4)));
    check("unmapped_led", {24'd0, LED}, 32'hA5);

    wr(8'h08, 5); wr(8'h10, 1); tick();
    rd("pre_rst_count", 8'h0C, 4);
    RESET = 0; model_reset();
    rd("rst_count", 8'h0C, 0);
    rd("rst_ctrl", 8'h10, 0);
    rd("rst_load", 8'h08, 0);
    check("rst_led", {24'd0, LED}, 0);
    check("rst_irq", {31'd0, IRQ}, 0);
    RESET = 1;
    tick(); tick();
    rd("post_rst_count", 8'h0C, 0);
    rd("post_rst_status", 8'h14, 0);

    wr(8'h08, 3); wr(8'h10, 5);
    rd("os_c3", 8'h0C, 3); tick();
    rd("os_c2", 8'h0C, 2); tick();
    rd("os_c1", 8'h0C, 1);
    check("os_noexp", {31'd0, IRQ}, 0);
    tick();
    rd("os_c0", 8'h0C, 0);
    rd("os_exp", 8'h14, 1);
    check("os_irq", {31'd0, IRQ}, 1);
    rd("os_ctrl", 8'h10, 4);
    tick();
    rd("os_hold", 8'h0C, 0);
    wr(8'h14, 0);
    check("os_st0_irq", {31'd0, IRQ}, 1);
    wr(8'h14, 1);
    check("os_st1_irq", {31'd0, IRQ}, 0);

    wr(8'h08, 4); wr(8'h10, 3);
    tick(); tick(); tick();
    rd("ar_pre", 8'h14, 0);
    tick();
    rd("ar_exp4", 8'h14, 1);
    rd("ar_reload", 8'h0C, 4);
    wr(8'h14, 1);
    rd("ar_clr", 8'h14, 0);
    tick(); tick();
    wr(8'h14, 1);
    rd("ar_setwins", 8'h14, 1);
    rd("ar_reload8", 8'h0C, 4);
    wr(8'h10, 0); wr(8'h14, 1);

    wr(8'h18, 0);
    SWITCH = 1; tick();
    rd("sw_lag1", 8'h04, 0); tick();
    rd("sw_lag2", 8'h04, 1); tick(); tick();
    SWITCH = 0; tick(); tick();
    rd("sw_fall", 8'h04, 0); tick(); tick();
    SWITCH = 1; tick(); tick(); tick(); tick();
    rd("edges2", 8'h18, 2);
    SWITCH = 0; tick(); tick(); tick(); tick();
    SWITCH = 1; tick(); tick();
    wr(8'h18, 0);
    rd("edge_clr_wins", 8'h18, 0);
    tick(); tick();
    rd("edge_clr_hold", 8'h18, 0);

    SWITCH = 0; tick(); tick(); tick(); tick();
    force dut.edges_q = 32'hFFFF_FFFF;
    #1;
    release dut.edges_q;
    m_edges = 32'hFFFF_FFFF;
    rd("wrap_pre", 8'h18, 32'hFFFF_FFFF);
    SWITCH = 1; tick(); tick(); tick();
    rd("wrap", 8'h18, 0);

    for (int n = 0; n < 600; n++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      A = ($urandom_range(0, 15) == 0) ? $urandom : BASE + {27'd0, o, 2'b00};
      WE = $urandom_range(0, 1) == 1;
      WD = (o == 2) ? $urandom_range(1, 6) : (o == 4) ? $urandom_range(0, 7) :
           (o == 5) ? $urandom_range(0, 1) : $urandom;
      if ($urandom_range(0, 3) == 0) SWITCH = 8'($urandom);
      tick();
      WE = 0;
      check("rnd_led", {24'd0, LED}, {24'd0, m_led});
      check("rnd_irq", {31'd0, IRQ}, {31'd0, m_exp & m_ctrl[2]});
      for (int i = 0; i < 7; i++) rd("rnd_rd", 8'(i * 4), m_rd(BASE + 32'(i * 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_timer_io.md
# mmio_timer_io

Memory-mapped I/O responder on the MIPS data-memory bus: the processor initiates single-cycle loads and stores, and this block answers them alongside the data memory. It owns an LED output register, synchronised switch inputs, a programmable down-counting timer with sticky expiry flag and interrupt, and a rising-edge event counter on switch bit 0. Reads are combinational in the same cycle as the address; writes commit on the clock edge.

## Interface
- BASE_ADDR, 32'h0000_FF00, block selected when A[31:8] == BASE_ADDR[31:8]
- LED_W, 8, width of LED register/output
- SW_W, 8, width of switch input

- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- A  in  32  byte address from ALU result; word offset = A[7:2]
- WE  in  1  store strobe from control unit
- WD  in  32  store data from register file port 2
- RD  out  32  read data; 0 when not selected
- SEL  out  1  combinational address match; top level muxes RD vs data memory
- SWITCH  in  SW_W  asynchronous switch pins
- LED  out  LED_W  LED register value
- IRQ  out  1  EXPIRED & CTRL[2]

## Operation
- Write commits at posedge CLK when WE & SEL; unmapped offsets ignored.
- Reads of unmapped offsets return 0; unused bits of every register read 0.
- Register map (offset A[7:0]):
  - 0x00 LED, RW, bits[LED_W-1:0].
  - 0x04 SWITCH, RO, 2-flop synchronised SWITCH.
  - 0x08 LOAD, RW, 32 bit; a write also loads COUNT with WD.
  - 0x0C COUNT, RO, 32 bit down-counter.
  - 0x10 CTRL, RW, bit0 EN, bit1 RELOAD, bit2 IRQEN.
  - 0x14 STATUS, bit0 EXPIRED sticky; writing 1 to bit0 clears it, writing 0 has no effect.
  - 0x18 EDGES, RO count of rising edges of synchronised SWITCH[0]; any write clears it.
- Timer, per cycle, in priority order:
  - LOAD write: COUNT <= WD; no decrement that cycle.
  - EN=1, COUNT>1: COUNT <= COUNT-1.
  - EN=1, COUNT==1: EXPIRED <= 1; COUNT <= RELOAD ? LOAD : 0; if RELOAD=0, EN <= 0.
  - EN=1, COUNT==0: hold; no expiry.
  - EN=0: hold.
- Simultaneous expiry and STATUS clear write: set wins, EXPIRED stays 1.
- Simultaneous EN clearing by hardware (one-shot) and a CTRL write: the CTRL write wins.
- Edge counter: increments when sync[0]=1 and the previous sync[0]=0; wraps 2^32-1 -> 0. A clear write in the same cycle as an edge gives 0 (clear wins).
- Reset (RESET=0, async): LED, LOAD, COUNT, CTRL, EXPIRED, EDGES and sync flops all 0; outputs RD=0 when unselected, LED=0, IRQ=0. Reset mid-count abandons the count with no expiry.

## Timing
- RD and SEL are combinational from A and current register state, with zero latency.
- A store is visible on RD and on LED in the cycle after the write edge.
- SWITCH change is visible at offset 0x04 after 2 rising edges. An EDGES increment is visible after 3 edges.
- Load N with EN=1 and RELOAD=0: EXPIRED rises exactly N edges after EN is first sampled 1. IRQ follows in the same cycle if IRQEN=1.
- RELOAD=1: period is LOAD cycles, so EXPIRED is set every LOAD cycles. LOAD=1 expires every cycle.

## Test plan
- Reset: assert RESET=0 mid-run with COUNT=5 and EN=1 -> all registers and IRQ read 0 immediately; after release, COUNT stays 0.
- Decode: store 0xA5 to BASE+0x00 -> LED=0xA5 next cycle. A=BASE+0x100 -> SEL=0, RD=0. A store to 0x1C changes nothing.
- One-shot: LOAD=3, CTRL=0x5 -> COUNT reads 3,2,1,0 on successive cycles; EXPIRED=1, IRQ=1, EN reads 0. Writing STATUS=0 keeps IRQ=1; writing STATUS=1 gives IRQ=0.
- Auto-reload: LOAD=4, CTRL=0x3 -> EXPIRED set at cycle 4. Writing STATUS=1 on the cycle 8 expiry edge leaves EXPIRED=1 (set wins).
- Switches: toggle SWITCH[0] 0->1->0->1 with 4-cycle spacing -> 0x04 tracks with 2-cycle lag and EDGES=2. A clear coincident with a third edge gives EDGES=0.
- Wrap: preload EDGES to 0xFFFFFFFF through a bench force, then one rising edge -> EDGES=0.
